trace_readout_sequencer: RTL and testbench

- Capture/readout sequencer for the trace buffer's single-port sample memory.
- While armed, it writes incoming trace words into a circular buffer and waits for a trigger. It then captures a programmable number of post-trigger words and freezes capture.
- It then streams the captured window, oldest word first, over a valid/ready interface toward the system-side data interface.

---
 rtl/trace_readout_sequencer_pkg.sv | 13 +
 rtl/trace_readout_sequencer_if.sv | 31 +++
 rtl/trace_readout_sequencer_rv_skid_buffer.sv | 55 +++++
 rtl/trace_readout_sequencer.sv | 138 +++++++++++++
 tb/tb_trace_readout_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_readout_sequencer_pkg.sv
// Shared types and defaults for the trace capture/readout sequencer.
package trace_readout_sequencer_pkg;
    localparam int SEQ_ADDR_WIDTH = 10;
    localparam int SEQ_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_POST    = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;
endpackage

// File: rtl/trace_readout_sequencer_if.sv
// Capture stream, single-port sample memory and readout stream of the sequencer.
interface trace_readout_sequencer_if
    import trace_readout_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = SEQ_DATA_WIDTH
);
    logic                  CAPT_VALID_I;
    logic [DATA_WIDTH-1:0] CAPT_DATA_I;
    logic                  CAPT_READY_O;
    logic [ADDR_WIDTH-1:0] MEM_ADDR_O;
    logic                  MEM_WE_O;
    logic [DATA_WIDTH-1:0] MEM_WDATA_O;
    logic                  MEM_RE_O;
    logic [DATA_WIDTH-1:0] MEM_RDATA_I;
    logic                  DATA_VALID_O;
    logic                  DATA_READY_I;
    logic [DATA_WIDTH-1:0] DATA_O;

    modport master (
        input  CAPT_VALID_I, CAPT_DATA_I, MEM_RDATA_I, DATA_READY_I,
        output CAPT_READY_O, MEM_ADDR_O, MEM_WE_O, MEM_WDATA_O, MEM_RE_O,
               DATA_VALID_O, DATA_O
    );

    modport slave (
        output CAPT_VALID_I, CAPT_DATA_I, MEM_RDATA_I, DATA_READY_I,
        input  CAPT_READY_O, MEM_ADDR_O, MEM_WE_O, MEM_WDATA_O, MEM_RE_O,
               DATA_VALID_O, DATA_O
    );
endinterface

// File: rtl/trace_readout_sequencer_rv_skid_buffer.sv
// Two-entry first-word-fall-through valid/ready FIFO with occupancy and flush.
module rv_skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_occ
);
    logic [DATA_WIDTH-1:0] r_d0, r_d1;
    logic [1:0]            r_cnt;
    logic                  w_pop;

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_d0;
    assign o_occ   = r_cnt;
    assign w_pop   = o_valid & i_ready;

    // Head entry only moves on a pop, so o_data holds while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else if (i_flush) begin
            r_cnt <= 2'd0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_d0 <= i_data;
                    else               r_d1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/trace_readout_sequencer.sv
// Circular pre/post-trigger capture into a single-port memory, then oldest-first readout.
module trace_readout_sequencer
    import trace_readout_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = SEQ_DATA_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic                  ARM_I,
    input  logic                  ABORT_I,
    input  logic                  TRIG_I,
    input  logic [ADDR_WIDTH-1:0] POST_COUNT_I,
    trace_readout_sequencer_if.master bus,
    output logic [2:0]            STATE_O,
    output logic                  WRAPPED_O,
    output logic                  DONE_O
);
    localparam logic [ADDR_WIDTH:0] FILL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    seq_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr, r_post;
    logic [ADDR_WIDTH:0]   r_fill, r_remaining, r_issued, r_sent;
    logic                  r_wrapped, r_capt_ready, r_done, r_inflight;

    logic                  w_we, w_re, w_pop, w_wrap_nxt, w_enter, w_last_hs;
    logic [ADDR_WIDTH-1:0] w_wptr_nxt;
    logic [ADDR_WIDTH:0]   w_fill_nxt;
    logic [1:0]            w_occ;
    logic [2:0]            w_load;

    assign w_we       = bus.CAPT_VALID_I & r_capt_ready & ~ABORT_I;
    assign w_wptr_nxt = r_wptr + ADDR_WIDTH'(w_we);
    assign w_wrap_nxt = r_wrapped | (w_we & (r_wptr == '1));
    assign w_fill_nxt = (w_we && r_fill != FILL_MAX) ? r_fill + CNT_ONE : r_fill;

    // Count the slot freed by this cycle's pop so a held-ready consumer sees one word per cycle.
    assign w_pop  = bus.DATA_VALID_O & bus.DATA_READY_I;
    assign w_load = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_re   = (r_state == ST_READOUT) & ~ABORT_I & (w_load < 3'd2) & (r_issued != r_remaining);
    assign w_last_hs = w_pop & ((r_sent + CNT_ONE) == r_remaining);

    assign w_enter = (r_state == ST_PRE  && TRIG_I && POST_COUNT_I == '0) ||
                     (r_state == ST_POST && w_we   && r_post == ADDR_WIDTH'(1));

    assign bus.CAPT_READY_O = r_capt_ready;
    assign bus.MEM_WE_O     = w_we;
    assign bus.MEM_WDATA_O  = w_we ? bus.CAPT_DATA_I : '0;
    assign bus.MEM_RE_O     = w_re;
    assign bus.MEM_ADDR_O   = r_capt_ready ? r_wptr :
                              (r_state == ST_READOUT) ? r_rptr : '0;
    assign STATE_O   = r_state;
    assign WRAPPED_O = r_wrapped;
    assign DONE_O    = r_done;

    rv_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .i_clk   (CLK_I),
        .i_rst_n (RST_NI),
        .i_flush (ABORT_I),
        .i_valid (r_inflight),
        .i_data  (bus.MEM_RDATA_I),
        .o_valid (bus.DATA_VALID_O),
        .o_data  (bus.DATA_O),
        .i_ready (bus.DATA_READY_I),
        .o_occ   (w_occ)
    );

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state      <= ST_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_post       <= '0;
            r_fill       <= '0;
            r_remaining  <= '0;
            r_issued     <= '0;
            r_sent       <= '0;
            r_wrapped    <= 1'b0;
            r_capt_ready <= 1'b0;
            r_done       <= 1'b0;
            r_inflight   <= 1'b0;
        end else if (ABORT_I) begin
            r_state      <= ST_IDLE;
            r_capt_ready <= 1'b0;
            r_done       <= 1'b0;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_re;
            if (w_we) begin
                r_wptr    <= w_wptr_nxt;
                r_wrapped <= w_wrap_nxt;
                r_fill    <= w_fill_nxt;
            end
            if (w_re) begin
                r_rptr   <= r_rptr + ADDR_WIDTH'(1);
                r_issued <= r_issued + CNT_ONE;
            end
            if (w_pop) r_sent <= r_sent + CNT_ONE;

            // Freeze capture; oldest word sits at write_ptr once the buffer has wrapped.
            if (w_enter) begin
                r_capt_ready <= 1'b0;
                r_rptr       <= w_wrap_nxt ? w_wptr_nxt : '0;
                r_remaining  <= w_fill_nxt;
                r_issued     <= '0;
                r_sent       <= '0;
                if (w_fill_nxt == '0) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_READOUT;
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: if (ARM_I) begin
                        r_state      <= ST_PRE;
                        r_capt_ready <= 1'b1;
                        r_done       <= 1'b0;
                        r_wptr       <= '0;
                        r_wrapped    <= 1'b0;
                        r_fill       <= '0;
                    end
                    ST_PRE: if (TRIG_I) begin
                        r_post  <= POST_COUNT_I;
                        r_state <= ST_POST;
                    end
                    ST_POST: if (w_we) r_post <= r_post - ADDR_WIDTH'(1);
                    ST_READOUT: if (w_last_hs) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trace_readout_sequencer.sv
// Randomized scoreboard bench: capture model predicts the readout window, monitor checks it.
module tb_trace_readout_sequencer;
    import trace_readout_sequencer_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          CLK_I = 1'b0;
    logic          RST_NI = 1'b0;
    logic          ARM_I = 1'b0;
    logic          ABORT_I = 1'b0;
    logic          TRIG_I = 1'b0;
    logic [AW-1:0] POST_COUNT_I = '0;
    logic [2:0]    STATE_O;
    logic          WRAPPED_O, DONE_O;

    trace_readout_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    trace_readout_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI), .ARM_I(ARM_I), .ABORT_I(ABORT_I),
        .TRIG_I(TRIG_I), .POST_COUNT_I(POST_COUNT_I), .bus(bus),
        .STATE_O(STATE_O), .WRAPPED_O(WRAPPED_O), .DONE_O(DONE_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Sample memory: synchronous write, one-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK_I) begin
        if (bus.MEM_WE_O) mem[bus.MEM_ADDR_O] <= bus.MEM_WDATA_O;
        if (bus.MEM_RE_O) bus.MEM_RDATA_I <= mem[bus.MEM_ADDR_O];
    end

    int vectors = 0, miscompares = 0;
    logic [31:0] exp_q[$];
    int ready_mode = 0;
    int cyc = 0, hs_cnt = 0, re_cnt = 0, run_len = 0, max_run = 0;
    int entry_cyc = 0, first_valid_cyc = 0;
    bit valid_seen = 0, first_re_seen = 0, first_we_seen = 0, stalled = 0;
    logic [AW-1:0] first_re_addr = '0, first_we_addr = '0;
    logic [31:0] stall_data = '0;
    logic [2:0]  prev_state = '0;
    bit exp_wrapped = 0;
    int exp_n = 0, exp_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        bus.DATA_READY_I = 1'b1;
        forever begin
            @(posedge CLK_I); #1;
            case (ready_mode)
                1:       bus.DATA_READY_I = ~bus.DATA_READY_I;
                2:       bus.DATA_READY_I = 1'($urandom_range(0, 1));
                default: bus.DATA_READY_I = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every readout handshake.
    initial begin
        forever begin
            @(negedge CLK_I);
            cyc++;
            if (!RST_NI) begin
                stalled = 0;
                run_len = 0;
            end else begin
                if (bus.MEM_WE_O && bus.MEM_RE_O) begin
                    miscompares++;
                    $display("FAIL mem_port_conflict: we=1 re=1 required not both (t=%0t)", $time);
                end
                if (STATE_O == 3'd3 && prev_state != 3'd3) entry_cyc = cyc;
                if (bus.MEM_RE_O) begin
                    re_cnt++;
                    if (!first_re_seen) begin first_re_seen = 1; first_re_addr = bus.MEM_ADDR_O; end
                end
                if (bus.MEM_WE_O && !first_we_seen) begin
                    first_we_seen = 1;
                    first_we_addr = bus.MEM_ADDR_O;
                end
                if (bus.DATA_VALID_O) begin
                    if (!valid_seen) begin valid_seen = 1; first_valid_cyc = cyc; end
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else run_len = 0;
                if (stalled) begin
                    check("stall_valid_held", 32'(bus.DATA_VALID_O), 32'd1);
                    if (bus.DATA_VALID_O) check("stall_data_held", bus.DATA_O, stall_data);
                end
                if (bus.DATA_VALID_O && bus.DATA_READY_I) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL readout_extra: got %0h expected no word", bus.DATA_O);
                    end else check("readout_word", bus.DATA_O, exp_q.pop_front());
                end
                stalled    = bus.DATA_VALID_O && !bus.DATA_READY_I;
                stall_data = bus.DATA_O;
            end
            prev_state = STATE_O;
        end
    end

    task automatic step(input bit v, input logic [31:0] d, input bit t);
        bus.CAPT_VALID_I = v;
        bus.CAPT_DATA_I  = d;
        TRIG_I = t;
        @(posedge CLK_I); #1;
        bus.CAPT_VALID_I = 1'b0;
        TRIG_I = 1'b0;
    endtask

    task automatic arm();
        ARM_I = 1'b1;
        @(posedge CLK_I); #1;
        ARM_I = 1'b0;
    endtask

    // Reference: readout is the last min(n, DEPTH) accepted words, oldest first.
    task automatic capture(input logic [31:0] pre[$], input logic [31:0] post[$],
                           input bit trig_w, input int gap);
        logic [31:0] all[$];
        all = {pre, post};
        exp_n = all.size();
        for (int i = (exp_n > DEPTH ? exp_n - DEPTH : 0); i < exp_n; i++) exp_q.push_back(all[i]);
        exp_wrapped = (exp_n >= DEPTH);
        exp_start   = exp_wrapped ? exp_n % DEPTH : 0;
        first_re_seen = 0; first_we_seen = 0; valid_seen = 0; max_run = 0;
        POST_COUNT_I = AW'(post.size());
        arm();
        for (int i = 0; i < pre.size(); i++) begin
            while ($urandom_range(0, 99) < gap) step(0, 32'h0, 0);
            step(1, pre[i], trig_w && (i == pre.size() - 1));
        end
        if (!trig_w || pre.size() == 0) step(0, 32'h0, 1);
        for (int i = 0; i < post.size(); i++) begin
            while ($urandom_range(0, 99) < gap) step(0, 32'h0, 0);
            step(1, post[i], 0);
        end
        step(1, 32'hDEAD0000 | 32'($urandom_range(0, 255)), 0);
        step(1, 32'hDEAD1000 | 32'($urandom_range(0, 255)), 0);
    endtask

    task automatic finish_check(input string tag);
        int k;
        k = 0;
        while (!DONE_O && k < 600) begin @(negedge CLK_I); k++; end
        check({tag, "_done"}, 32'(DONE_O), 32'd1);
        check({tag, "_state"}, 32'(STATE_O), 32'(ST_DONE));
        check({tag, "_wrapped"}, 32'(WRAPPED_O), 32'(exp_wrapped));
        check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        if (exp_n > 0) begin
            check({tag, "_rd_start"}, 32'(first_re_addr), 32'(exp_start));
            check({tag, "_latency"}, 32'(first_valid_cyc - entry_cyc), 32'd2);
        end else check({tag, "_no_valid"}, 32'(valid_seen), 32'd0);
    endtask

    logic [31:0] qa[$], qb[$];

    initial begin
        int k, hs0, re0, npre, npost;
        bus.CAPT_VALID_I = 1'b0;
        bus.CAPT_DATA_I  = '0;
        #12;
        check("rst_state", 32'(STATE_O), 32'd0);
        check("rst_valid", 32'(bus.DATA_VALID_O), 32'd0);
        check("rst_ready", 32'(bus.CAPT_READY_O), 32'd0);
        check("rst_done", 32'(DONE_O), 32'd0);
        check("rst_wrapped", 32'(WRAPPED_O), 32'd0);
        check("rst_re_we", 32'({bus.MEM_RE_O, bus.MEM_WE_O}), 32'd0);
        @(posedge CLK_I); #1;
        RST_NI = 1'b1;
        @(posedge CLK_I); #1;

        // Basic window, ready held high
        ready_mode = 0;
        qa = {32'h10, 32'h11, 32'h12}; qb = {32'h13, 32'h14};
        capture(qa, qb, 1, 0);
        finish_check("basic");
        check("basic_consecutive", 32'(max_run), 32'd5);

        // Wrapped buffer
        qa.delete(); qb.delete();
        for (int i = 0; i < 20; i++) qa.push_back(32'(i));
        qb = {32'd20, 32'd21, 32'd22};
        capture(qa, qb, 1, 0);
        finish_check("wrap");

        // Alternating consumer stall
        ready_mode = 1;
        qa = {32'h10, 32'h11, 32'h12}; qb = {32'h13, 32'h14};
        capture(qa, qb, 1, 0);
        finish_check("stall");

        // Empty capture: trigger with nothing written
        ready_mode = 0;
        valid_seen = 0; first_we_seen = 0;
        POST_COUNT_I = '0;
        arm();
        step(0, 32'h0, 1);
        check("empty_done", 32'(DONE_O), 32'd1);
        check("empty_state", 32'(STATE_O), 32'(ST_DONE));
        step(1, 32'hBAD0, 0);
        repeat (3) @(posedge CLK_I); #1;
        check("empty_no_valid", 32'(valid_seen), 32'd0);
        check("empty_no_write", 32'(first_we_seen), 32'd0);

        // Abort mid-readout
        qa.delete(); qb.delete();
        for (int i = 0; i < 16; i++) qa.push_back(32'h100 + 32'(i));
        hs0 = hs_cnt;
        capture(qa, qb, 1, 0);
        k = 0;
        while (hs_cnt < hs0 + 3 && k < 200) begin @(negedge CLK_I); k++; end
        check("abort_reach3", 32'(hs_cnt >= hs0 + 3), 32'd1);
        @(posedge CLK_I); #1;
        ABORT_I = 1'b1;
        @(posedge CLK_I); #1;
        check("abort_state", 32'(STATE_O), 32'd0);
        check("abort_valid", 32'(bus.DATA_VALID_O), 32'd0);
        ABORT_I = 1'b0;
        exp_q.delete();
        re0 = re_cnt;
        repeat (5) @(posedge CLK_I); #1;
        check("abort_no_re", 32'(re_cnt), 32'(re0));
        qa = {32'hA0, 32'hA1, 32'hA2}; qb = {32'hA3};
        capture(qa, qb, 0, 0);
        check("rearm_wptr0", 32'(first_we_addr), 32'd0);
        finish_check("rearm");

        // Asynchronous reset during POST
        arm();
        POST_COUNT_I = 4'd5;
        step(1, 32'h1, 0); step(1, 32'h2, 0); step(0, 32'h0, 1);
        step(1, 32'h3, 0);
        bus.CAPT_VALID_I = 1'b1;
        bus.CAPT_DATA_I  = 32'h4;
        #3 RST_NI = 1'b0;
        #1;
        check("arst_state", 32'(STATE_O), 32'd0);
        check("arst_we", 32'(bus.MEM_WE_O), 32'd0);
        check("arst_capt_ready", 32'(bus.CAPT_READY_O), 32'd0);
        bus.CAPT_VALID_I = 1'b0;
        @(posedge CLK_I); #1;
        RST_NI = 1'b1;
        step(0, 32'h0, 1);
        check("arst_trig_ignored", 32'(STATE_O), 32'd0);
        exp_q.delete();

        // Randomized captures
        for (int it = 0; it < 12; it++) begin
            npre  = $urandom_range(0, 30);
            npost = $urandom_range(0, 15);
            qa.delete(); qb.delete();
            for (int i = 0; i < npre; i++)  qa.push_back($urandom);
            for (int i = 0; i < npost; i++) qb.push_back($urandom);
            ready_mode = $urandom_range(0, 2);
            capture(qa, qb, 1'($urandom_range(0, 1)), $urandom_range(0, 40));
            finish_check($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
